// File: rtl/n101_qspi_slave_media.sv
// -----------------------------------------------------------------------------
// n101_qspi_slave_media
//
// SPI/QSPI target (responder) media layer. This is the far-end counterpart of
// the n101 QSPI master media/phy pair. SCK and CS come from an external master
// and are resynchronised into the `clock` domain. Incoming lane data is
// deserialised into bytes for the link rx side, and bytes pulled from the link
// tx side are serialised onto DQ. Supports single/dual/quad lanes, all four
// SCK modes and MSB- or LSB-first bit order.
//
// State table:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | CS high or block disabled; all lanes released
//   ST_ACTIVE | selected; sampling on the sample edge, shifting on the other
//
// Ports:
//   clock, reset              system clock, async active-high reset
//   io_port_sck, io_port_cs_0 master SCK and active-low chip select
//   io_port_dq_N_i/_o/_oe     data lanes 0..3 (input, output, output enable)
//   io_ctrl_*                 enable, CPOL, CPHA, protocol, bit order, iodir
//   io_link_tx_*              tx byte source (ready is the load strobe)
//   io_link_rx_*              received byte and one-cycle valid pulse
//   io_link_tx_underrun       load strobe with no tx byte available
//   io_link_active            high while selected
// -----------------------------------------------------------------------------
module n101_qspi_slave_media #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_port_sck,
    input  logic       io_port_cs_0,
    input  logic       io_port_dq_0_i,
    input  logic       io_port_dq_1_i,
    input  logic       io_port_dq_2_i,
    input  logic       io_port_dq_3_i,
    output logic       io_port_dq_0_o,
    output logic       io_port_dq_1_o,
    output logic       io_port_dq_2_o,
    output logic       io_port_dq_3_o,
    output logic       io_port_dq_0_oe,
    output logic       io_port_dq_1_oe,
    output logic       io_port_dq_2_oe,
    output logic       io_port_dq_3_oe,
    input  logic       io_ctrl_en,
    input  logic       io_ctrl_sck_pol,
    input  logic       io_ctrl_sck_pha,
    input  logic [1:0] io_ctrl_fmt_proto,
    input  logic       io_ctrl_fmt_endian,
    input  logic       io_ctrl_fmt_iodir,
    output logic       io_link_tx_ready,
    input  logic       io_link_tx_valid,
    input  logic [7:0] io_link_tx_bits,
    output logic       io_link_rx_valid,
    output logic [7:0] io_link_rx_bits,
    output logic       io_link_tx_underrun,
    output logic       io_link_active
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] PROTO_DUAL = 2'd1;
    localparam logic [1:0] PROTO_QUAD = 2'd2;

    // Lane data driven onto dq[3:0] for the current shift register contents.
    // Single mode drives MISO on dq1; dual/quad put the group LSB on dq0.
    function automatic logic [3:0] tx_group(input logic [7:0] sh,
                                            input logic [1:0] proto,
                                            input logic       lsb_first);
        logic [3:0] g;
        if (proto == PROTO_QUAD) begin
            g = lsb_first ? sh[3:0] : sh[7:4];
        end else if (proto == PROTO_DUAL) begin
            g = lsb_first ? {2'b00, sh[1:0]} : {2'b00, sh[7:6]};
        end else begin
            g = {2'b00, (lsb_first ? sh[0] : sh[7]), 1'b0};
        end
        return g;
    endfunction

    function automatic logic [3:0] lane_oe(input logic [1:0] proto,
                                           input logic       iodir);
        logic [3:0] oe;
        if (proto == PROTO_QUAD) begin
            oe = iodir ? 4'b0000 : 4'b1111;
        end else if (proto == PROTO_DUAL) begin
            oe = iodir ? 4'b0000 : 4'b0011;
        end else begin
            oe = 4'b0010;
        end
        return oe;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    state_t                 state_q, state_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   pol_q, pol_d;
    logic                   pha_q, pha_d;
    logic [1:0]             proto_q, proto_d;
    logic                   endian_q, endian_d;
    logic                   iodir_q, iodir_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_sh_q, rx_sh_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   sampled_q, sampled_d;
    logic [7:0]             rx_bits_q, rx_bits_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [3:0]             dq_o_q, dq_o_d;
    logic [3:0]             dq_oe_q, dq_oe_d;

    logic       sck_s, cs_s;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       is_dual, is_quad, rx_en, cnt_last, byte_done;
    logic [3:0] group_in;
    logic [7:0] rx_next, shift_next, load_byte;
    logic       tx_load;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];

    // Edges are judged against the CPOL captured at selection time.
    assign lead_edge   = (sck_s != pol_q) && (sck_prev_q == pol_q);
    assign trail_edge  = (sck_s == pol_q) && (sck_prev_q != pol_q);
    assign sample_edge = pha_q ? trail_edge : lead_edge;
    assign shift_edge  = pha_q ? lead_edge : trail_edge;

    assign is_dual  = (proto_q == PROTO_DUAL);
    assign is_quad  = (proto_q == PROTO_QUAD);
    assign rx_en    = !(is_dual || is_quad) || iodir_q;
    assign cnt_last = is_quad ? (cnt_q == 3'd1) :
                      is_dual ? (cnt_q == 3'd3) : (cnt_q == 3'd7);
    // The counter wraps to 0 on the last sample, so 0 with a sample taken
    // means the whole byte has been clocked.
    assign byte_done = sampled_q && (cnt_q == 3'd0);

    assign group_in  = {io_port_dq_3_i, io_port_dq_2_i, io_port_dq_1_i, io_port_dq_0_i};
    assign load_byte = io_link_tx_valid ? io_link_tx_bits : 8'hFF;

    always_comb begin
        if (is_quad) begin
            rx_next    = endian_q ? {group_in, rx_sh_q[7:4]} : {rx_sh_q[3:0], group_in};
            shift_next = endian_q ? {4'h0, shift_q[7:4]} : {shift_q[3:0], 4'h0};
        end else if (is_dual) begin
            rx_next    = endian_q ? {group_in[1:0], rx_sh_q[7:2]} : {rx_sh_q[5:0], group_in[1:0]};
            shift_next = endian_q ? {2'b00, shift_q[7:2]} : {shift_q[5:0], 2'b00};
        end else begin
            rx_next    = endian_q ? {group_in[0], rx_sh_q[7:1]} : {rx_sh_q[6:0], group_in[0]};
            shift_next = endian_q ? {1'b0, shift_q[7:1]} : {shift_q[6:0], 1'b0};
        end
    end

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], io_port_sck};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], io_port_cs_0};
        sck_prev_d = sck_s;
        state_d    = state_q;
        pol_d      = pol_q;
        pha_d      = pha_q;
        proto_d    = proto_q;
        endian_d   = endian_q;
        iodir_d    = iodir_q;
        shift_d    = shift_q;
        rx_sh_d    = rx_sh_q;
        cnt_d      = cnt_q;
        sampled_d  = sampled_q;
        rx_bits_d  = rx_bits_q;
        rx_valid_d = 1'b0;
        tx_load    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (!cs_s && io_ctrl_en) begin
                state_d   = ST_ACTIVE;
                pol_d     = io_ctrl_sck_pol;
                pha_d     = io_ctrl_sck_pha;
                proto_d   = io_ctrl_fmt_proto;
                endian_d  = io_ctrl_fmt_endian;
                iodir_d   = io_ctrl_fmt_iodir;
                tx_load   = 1'b1;
                shift_d   = load_byte;
                rx_sh_d   = 8'h00;
                cnt_d     = 3'd0;
                sampled_d = 1'b0;
            end
        end else begin
            // Deselect wins over any edge seen in the same cycle.
            if (cs_s || !io_ctrl_en) begin
                state_d = ST_IDLE;
            end else if (sample_edge) begin
                rx_sh_d   = rx_next;
                sampled_d = 1'b1;
                if (cnt_last) begin
                    cnt_d = 3'd0;
                    if (rx_en) begin
                        rx_bits_d  = rx_next;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else if (shift_edge && sampled_q) begin
                // A shift edge before any sample (CPHA=1 first leading edge)
                // is not a real shift and is skipped by the sampled_q gate.
                if (byte_done) begin
                    tx_load   = 1'b1;
                    shift_d   = load_byte;
                    sampled_d = 1'b0;
                end else begin
                    shift_d = shift_next;
                end
            end
        end

        dq_o_d  = (state_d == ST_ACTIVE) ? tx_group(shift_d, proto_d, endian_d) : 4'b0000;
        dq_oe_d = (state_d == ST_ACTIVE) ? lane_oe(proto_d, iodir_d) : 4'b0000;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            state_q    <= ST_IDLE;
            sck_prev_q <= 1'b0;
            pol_q      <= 1'b0;
            pha_q      <= 1'b0;
            proto_q    <= 2'd0;
            endian_q   <= 1'b0;
            iodir_q    <= 1'b0;
            shift_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            cnt_q      <= 3'd0;
            sampled_q  <= 1'b0;
            rx_bits_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            dq_o_q     <= 4'b0000;
            dq_oe_q    <= 4'b0000;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            state_q    <= state_d;
            sck_prev_q <= sck_prev_d;
            pol_q      <= pol_d;
            pha_q      <= pha_d;
            proto_q    <= proto_d;
            endian_q   <= endian_d;
            iodir_q    <= iodir_d;
            shift_q    <= shift_d;
            rx_sh_q    <= rx_sh_d;
            cnt_q      <= cnt_d;
            sampled_q  <= sampled_d;
            rx_bits_q  <= rx_bits_d;
            rx_valid_q <= rx_valid_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    // The tx handshake is combinational so the producer can pop in the same
    // cycle the byte is captured into the shift register.
    assign io_link_tx_ready    = tx_load;
    assign io_link_tx_underrun = tx_load & ~io_link_tx_valid;
    assign io_link_rx_valid    = rx_valid_q;
    assign io_link_rx_bits     = rx_bits_q;
    assign io_link_active      = (state_q == ST_ACTIVE);

    assign io_port_dq_0_o  = dq_o_q[0];
    assign io_port_dq_1_o  = dq_o_q[1];
    assign io_port_dq_2_o  = dq_o_q[2];
    assign io_port_dq_3_o  = dq_o_q[3];
    assign io_port_dq_0_oe = dq_oe_q[0];
    assign io_port_dq_1_oe = dq_oe_q[1];
    assign io_port_dq_2_oe = dq_oe_q[2];
    assign io_port_dq_3_oe = dq_oe_q[3];

endmodule
